// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between writeback, the long-latency unit, the arbiter and the register file.
interface regfile_write_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        RegWrite;
  logic [4:0]  RdW;
  logic [31:0] WD;
  logic [31:0] pending_mask;
  logic        stall_wb;

  modport master (
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, RegWrite, RdW, WD, pending_mask, stall_wb
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    output lu_ready, RegWrite, RdW, WD, pending_mask, stall_wb
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback wins, long-latency results queue in a FIFO and drain into idle slots.
// Optional REGFILE_ARB_BYPASS_EN grants an lu write straight to the port when the FIFO is empty and wb is idle.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_NORMAL, S_FORCE} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW:0]      r_wptr, r_rptr;
  logic [DEPTH-1:0] r_live;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [7:0]       r_starve, w_starve_nxt;
  logic             r_regwrite;
  logic [4:0]       r_rdw;
  logic [31:0]      r_wd;

  logic [AW-1:0]    w_ridx, w_widx;
  logic             w_empty, w_full, w_head_live, w_lu_fire, w_wb_req;
  logic             w_gnt, w_gnt_wb, w_pop, w_push, w_bypass;
  logic [4:0]       w_gnt_rd;
  logic [31:0]      w_gnt_data, w_mask;
  logic [DEPTH-1:0] w_squash;

  assign w_ridx      = r_rptr[AW-1:0];
  assign w_widx      = r_wptr[AW-1:0];
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (w_widx == w_ridx) && (r_wptr[AW] != r_rptr[AW]);
  assign w_head_live = !w_empty && r_live[w_ridx];
  assign w_lu_fire   = bus.lu_valid && !w_full;
  assign w_wb_req    = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign w_push      = w_lu_fire && (bus.lu_rd != 5'd0) && !w_bypass;

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt        = 1'b0;
    w_gnt_wb     = 1'b0;
    w_gnt_rd     = '0;
    w_gnt_data   = '0;
    w_pop        = 1'b0;
    w_bypass     = 1'b0;
    w_starve_nxt = r_starve;
    case (r_state)
      S_NORMAL: begin
        if (w_wb_req) begin
          w_gnt      = 1'b1;
          w_gnt_wb   = 1'b1;
          w_gnt_rd   = bus.wb_rd;
          w_gnt_data = bus.wb_data;
        end else if (w_head_live) begin
          w_gnt      = 1'b1;
          w_gnt_rd   = r_rd[w_ridx];
          w_gnt_data = r_data[w_ridx];
          w_pop      = 1'b1;
`ifdef REGFILE_ARB_BYPASS_EN
        end else if (w_empty && w_lu_fire && (bus.lu_rd != 5'd0)) begin
          w_gnt      = 1'b1;
          w_bypass   = 1'b1;
          w_gnt_rd   = bus.lu_rd;
          w_gnt_data = bus.lu_data;
`endif
        end
        // A squashed head is retired without a write, even while wb owns the port.
        if (!w_empty && !r_live[w_ridx]) w_pop = 1'b1;
      end
      S_FORCE: begin
        if (w_head_live) begin
          w_gnt      = 1'b1;
          w_gnt_rd   = r_rd[w_ridx];
          w_gnt_data = r_data[w_ridx];
        end
        w_pop       = !w_empty;
        w_state_nxt = S_NORMAL;
      end
      default: w_state_nxt = S_NORMAL;
    endcase

    if (r_state == S_FORCE || w_pop || w_empty)
      w_starve_nxt = '0;
    else if (w_head_live && w_gnt_wb && r_starve != 8'hFF)
      w_starve_nxt = r_starve + 8'd1;

    if (r_state == S_NORMAL && w_starve_nxt >= 8'(STARVE_LIMIT))
      w_state_nxt = S_FORCE;
  end

  always_comb begin
    w_squash = '0;
    w_mask   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_squash[i] = w_gnt_wb && (r_rd[i] == bus.wb_rd);
      if (r_live[i]) w_mask[r_rd[i]] = 1'b1;
    end
    w_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_NORMAL;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_live     <= '0;
      r_starve   <= '0;
      r_regwrite <= 1'b0;
      r_rdw      <= '0;
      r_wd       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_squash[i]) r_live[i] <= 1'b0;
      if (w_pop) begin
        r_live[w_ridx] <= 1'b0;
        r_rptr         <= r_rptr + 1'b1;
      end
      // Same-cycle push is younger than the squashing wb write, so it stays live.
      if (w_push) begin
        r_live[w_widx] <= 1'b1;
        r_wptr         <= r_wptr + 1'b1;
      end
      r_starve   <= w_starve_nxt;
      r_regwrite <= w_gnt;
      if (w_gnt) begin
        r_rdw <= w_gnt_rd;
        r_wd  <= w_gnt_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[w_widx]   <= bus.lu_rd;
      r_data[w_widx] <= bus.lu_data;
    end
  end

  assign bus.lu_ready     = !w_full;
  assign bus.RegWrite     = r_regwrite;
  assign bus.RdW          = r_rdw;
  assign bus.WD           = r_wd;
  assign bus.pending_mask = w_mask;
  assign bus.stall_wb     = (r_state == S_FORCE);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed + random bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus();
  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve;
  bit          m_force;
  bit          m_rw;
  logic [4:0]  m_rdw;
  logic [31:0] m_wd;
  int          npass = 0;
  int          nfail = 0;
  int          ntotal = 0;
  string       phase = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_data = '0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0; m_force = 1'b0; m_rw = 1'b0; m_rdw = '0; m_wd = '0;
  endtask

  // One clock: check state-derived outputs, advance the model, then check the write register.
  task automatic cycle();
    logic [31:0] mask;
    bit          g, popped, byp, was_empty, head_live, wbg, lu_fire, nforce;
    logic [4:0]  grd;
    logic [31:0] gd;
    ent_t        e;
    int          nxt;
    if (m_force) bus.wb_valid = 1'b0;
    mask = '0;
    foreach (m_q[i]) if (m_q[i].live) mask[m_q[i].rd] = 1'b1;
    check("lu_ready", 32'(bus.lu_ready), 32'(m_q.size() < DEPTH));
    check("pending_mask", bus.pending_mask, mask);
    check("stall_wb", 32'(bus.stall_wb), 32'(m_force));

    g = 1'b0; popped = 1'b0; byp = 1'b0; wbg = 1'b0; grd = '0; gd = '0;
    was_empty = (m_q.size() == 0);
    head_live = !was_empty && m_q[0].live;
    lu_fire   = bus.lu_valid && (m_q.size() < DEPTH);
    if (m_force) begin
      if (!was_empty) begin
        if (head_live) begin g = 1'b1; grd = m_q[0].rd; gd = m_q[0].data; end
        void'(m_q.pop_front());
        popped = 1'b1;
      end
    end else begin
      wbg = bus.wb_valid && (bus.wb_rd != 5'd0);
      if (wbg) begin
        g = 1'b1; grd = bus.wb_rd; gd = bus.wb_data;
      end else if (head_live) begin
        g = 1'b1; grd = m_q[0].rd; gd = m_q[0].data;
        void'(m_q.pop_front());
        popped = 1'b1;
`ifdef REGFILE_ARB_BYPASS_EN
      end else if (was_empty && lu_fire && bus.lu_rd != 5'd0) begin
        g = 1'b1; byp = 1'b1; grd = bus.lu_rd; gd = bus.lu_data;
`endif
      end
      if (!popped && !was_empty && !head_live) begin
        void'(m_q.pop_front());
        popped = 1'b1;
      end
      if (wbg) foreach (m_q[i]) if (m_q[i].rd == bus.wb_rd) m_q[i].live = 1'b0;
    end
    if (lu_fire && bus.lu_rd != 5'd0 && !byp) begin
      e.live = 1'b1; e.rd = bus.lu_rd; e.data = bus.lu_data;
      m_q.push_back(e);
    end
    if (m_force || popped || was_empty)  nxt = 0;
    else if (head_live && wbg)           nxt = (m_starve >= 255) ? 255 : m_starve + 1;
    else                                 nxt = m_starve;
    nforce = !m_force && (nxt >= LIM);

    @(posedge clk); #1;
    m_starve = nxt; m_force = nforce; m_rw = g;
    if (g) begin m_rdw = grd; m_wd = gd; end
    check("RegWrite", 32'(bus.RegWrite), 32'(m_rw));
    check("RdW", 32'(bus.RdW), 32'(m_rdw));
    check("WD", bus.WD, m_wd);
  endtask

  initial begin
    int blocked;
    idle();
    model_reset();
    reset_n = 1'b0;
    #1;
    phase = "reset";
    check("RegWrite", 32'(bus.RegWrite), 32'd0);
    check("RdW", 32'(bus.RdW), 32'd0);
    check("WD", bus.WD, 32'd0);
    check("lu_ready", 32'(bus.lu_ready), 32'd1);
    check("pending_mask", bus.pending_mask, 32'd0);
    check("stall_wb", 32'(bus.stall_wb), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    phase = "wb";
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    cycle();
    check("wb_rw", 32'(bus.RegWrite), 32'd1);
    check("wb_rd", 32'(bus.RdW), 32'd5);
    check("wb_wd", bus.WD, 32'hDEADBEEF);
    idle(); cycle();

    phase = "starve";
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 32'h5555_0000;
    bus.lu_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.lu_rd = 5'(k); bus.lu_data = 32'h100 + 32'(k);
      cycle();
    end
    bus.lu_valid = 1'b0;
    check("full_ready", 32'(bus.lu_ready), 32'd0);
    check("full_mask", bus.pending_mask, 32'h1E);
    blocked = 3;
    while (!bus.stall_wb && blocked < 40) begin cycle(); blocked++; end
    check("blocked_cycles", 32'(blocked), 32'(LIM));
    check("stall_on", 32'(bus.stall_wb), 32'd1);
    cycle();
    check("force_rw", 32'(bus.RegWrite), 32'd1);
    check("force_rd", 32'(bus.RdW), 32'd1);
    check("stall_off", 32'(bus.stall_wb), 32'd0);
    idle();
    repeat (6) cycle();

    phase = "waw";
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 32'h7777;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd3; bus.lu_data = 32'h33;
    cycle();
    bus.lu_rd = 5'd7; bus.lu_data = 32'h11;
    cycle();
    bus.lu_valid = 1'b0;
    check("mask7_set", 32'(bus.pending_mask[7]), 32'd1);
    bus.wb_rd = 5'd7; bus.wb_data = 32'h22;
    cycle();
    check("waw_rd", 32'(bus.RdW), 32'd7);
    check("waw_wd", bus.WD, 32'h22);
    check("mask7_clear", 32'(bus.pending_mask[7]), 32'd0);
    idle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("no_stale7", 32'(bus.RegWrite && bus.RdW == 5'd7), 32'd0);
    end

    phase = "rd0";
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'hBAD0;
    check("rd0_ready", 32'(bus.lu_ready), 32'd1);
    cycle();
    bus.lu_valid = 1'b0;
    check("rd0_lu_rw", 32'(bus.RegWrite), 32'd0);
    cycle();
    check("rd0_lu_rw2", 32'(bus.RegWrite), 32'd0);
    check("rd0_mask", bus.pending_mask, 32'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hBAD1;
    cycle();
    check("rd0_wb_rw", 32'(bus.RegWrite), 32'd0);
    idle(); cycle();

    phase = "bypass";
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'hCAFE;
    cycle();
    bus.lu_valid = 1'b0;
`ifdef REGFILE_ARB_BYPASS_EN
    check("byp_n1_rw", 32'(bus.RegWrite), 32'd1);
    check("byp_n1_rd", 32'(bus.RdW), 32'd9);
    cycle();
    check("byp_n2_rw", 32'(bus.RegWrite), 32'd0);
`else
    check("byp_n1_rw", 32'(bus.RegWrite), 32'd0);
    cycle();
    check("byp_n2_rw", 32'(bus.RegWrite), 32'd1);
    check("byp_n2_rd", 32'(bus.RdW), 32'd9);
    check("byp_n2_wd", bus.WD, 32'hCAFE);
`endif
    cycle();

    phase = "random";
    for (int k = 0; k < 600; k++) begin
      bus.wb_valid = ($urandom_range(0, 99) < 60);
      bus.wb_rd    = 5'($urandom_range(0, 12));
      bus.wb_data  = $urandom;
      bus.lu_valid = ($urandom_range(0, 99) < 45);
      bus.lu_rd    = 5'($urandom_range(0, 12));
      bus.lu_data  = $urandom;
      cycle();
    end
    idle();
    repeat (12) cycle();

    phase = "reset_mid";
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 32'h9999;
    bus.lu_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.lu_rd = 5'(10 + k); bus.lu_data = 32'hA0 + 32'(k);
      cycle();
    end
    bus.lu_valid = 1'b0;
    check("pre_mask", bus.pending_mask, 32'h1C00);
    reset_n = 1'b0;
    #1;
    check("rst_rw", 32'(bus.RegWrite), 32'd0);
    check("rst_mask", bus.pending_mask, 32'd0);
    check("rst_ready", 32'(bus.lu_ready), 32'd1);
    check("rst_stall", 32'(bus.stall_wb), 32'd0);
    model_reset();
    idle();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("no_stale", 32'(bus.RegWrite), 32'd0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
